// File: rtl/ifetch_axi.sv
// ifetch_axi: instruction fetch stage in front of the instruction BRAM.
// Keeps the PC and issues single-word reads on the AXI-lite AR/R channels, with at
// most one read outstanding. Returned words are buffered with their PCs and a
// bus-error flag, and handed to decode over valid/ready. A redirect flushes the
// buffer and drops the one in-flight beat, if there is one.
// Optional build macro IFETCH_PERF_EN adds the perf_* counter outputs.
//
// state | meaning
// IDLE  | no read outstanding; issue when the buffer has a free slot and not halted
// ADDR  | m_arvalid/m_araddr held stable until m_arready
// DATA  | address accepted, waiting for the R beat
module ifetch_axi #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_err,
`ifdef IFETCH_PERF_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt,
`endif
  input  logic        inst_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic          discard;
  logic          halted;

  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic          fifo_err  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic ar_hs;
  logic beat;
  logic push;
  logic pop;
  logic bus_err;
  logic can_issue;

  // m_arvalid is only ever high in ADDR, so the handshake reduces to ADDR & m_arready.
  // An R beat is only taken once its address has been accepted.
  assign ar_hs     = (state == ADDR) && m_arready;
  assign beat      = m_rvalid && ((state == DATA) || ar_hs);
  assign bus_err   = (m_rresp != 2'b00);
  assign push      = beat && !discard && !redirect_valid;
  assign pop       = inst_valid && inst_ready && !redirect_valid;
  // Reserving a slot at issue time means an accepted beat can never overflow the buffer.
  assign can_issue = (count < DEPTH_C) && !halted;

  assign inst_valid = (count != '0);
  assign inst_data  = fifo_data[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];
  assign inst_err   = fifo_err[rd_ptr];

  // Fetch FSM: AR/R sequencing, PC update, discard and halt tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      m_araddr  <= RESET_PC;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      discard   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A redirect in IDLE holds off issue for one cycle so the new pc is used.
          if (can_issue && !redirect_valid) begin
            m_araddr  <= pc;
            m_arvalid <= 1'b1;
            m_rready  <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            // pc already points at a redirect target when this read is stale.
            if (!discard && !redirect_valid) pc <= pc + 32'd4;
            if (m_rvalid) begin
              m_rready <= 1'b0;
              state    <= IDLE;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (m_rvalid) begin
            m_rready <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          m_arvalid <= 1'b0;
          m_rready  <= 1'b0;
          state     <= IDLE;
        end
      endcase

      if (beat) begin
        discard <= 1'b0;
        if (push && bus_err) halted <= 1'b1;
      end

      // A beat landing in the redirect cycle is dropped outright; otherwise the
      // still-outstanding read gets flagged for discard.
      if (redirect_valid) begin
        pc      <= {redirect_pc[31:2], 2'b00};
        halted  <= 1'b0;
        discard <= (state != IDLE) && !beat;
      end
    end
  end

  // Instruction buffer: circular FIFO, flushed by redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
        fifo_err[i]  <= 1'b0;
      end
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= m_rdata;
        fifo_pc[wr_ptr]   <= m_araddr;
        fifo_err[wr_ptr]  <= bus_err;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef IFETCH_PERF_EN
  // Free-running performance counters; all wrap on overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pop)                    perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!inst_valid && !halted) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect_valid)         perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_axi.sv
// Directed testbench for ifetch_axi with a small AXI-lite read slave model.
// Slave memory word at address a: 32'h00000013 for a==0, else a ^ 32'hDEAD0000.
module tb_ifetch_axi;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rvalid = 1'b0;
  logic        m_rready;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        inst_ready = 1'b0;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // slave configuration and state
  int          ar_wait = 1;
  int          r_wait = 0;
  bit          err_en = 0;
  logic [31:0] err_addr = '0;
  int          a_cnt = 0;
  int          r_cnt = 0;
  bit          r_pend = 0;
  logic [31:0] r_addr = '0;

  logic [31:0] ar_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_data_q[$];
  logic [31:0] pop_err_q[$];

  always #5 clk = ~clk;

  ifetch_axi #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_err(inst_err),
`ifdef IFETCH_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .inst_ready(inst_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0000_0013 : (a ^ 32'hDEAD_0000);
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_r(input logic [31:0] a);
    m_rvalid = 1'b1;
    m_rdata  = mem_word(a);
    m_rresp  = (err_en && a == err_addr) ? 2'b10 : 2'b00;
  endtask

  // Slave: arready comes ar_wait cycles after arvalid is seen; rvalid either
  // with arready (r_wait==0) or r_wait cycles after the address handshake.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        r_pend    = 0;
        a_cnt     = 0;
      end else begin
        if (m_rvalid) m_rvalid = 1'b0;
        if (m_arready) begin
          m_arready = 1'b0;
          if (r_wait > 0) begin
            r_pend = 1;
            r_cnt  = r_wait;
          end
        end else if (r_pend) begin
          r_cnt--;
          if (r_cnt == 0) begin
            r_pend = 0;
            drive_r(r_addr);
          end
        end else if (m_arvalid) begin
          if (a_cnt < ar_wait) a_cnt++;
          else begin
            a_cnt     = 0;
            m_arready = 1'b1;
            r_addr    = m_araddr;
            if (r_wait == 0) drive_r(m_araddr);
          end
        end
      end
    end
  end

  // Record AR handshakes and buffer pops that will happen at the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      if (m_arvalid && m_arready) ar_q.push_back(m_araddr);
      if (inst_valid && inst_ready && !redirect_valid) begin
        pop_pc_q.push_back(inst_pc);
        pop_data_q.push_back(inst_data);
        pop_err_q.push_back({31'b0, inst_err});
      end
    end
  end

  task automatic do_reset(input logic rdy, input int aw, input int rw);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = rdy;
    ar_wait        = aw;
    r_wait         = rw;
    err_en         = 0;
    tick(3);
    ar_q.delete();
    pop_pc_q.delete();
    pop_data_q.delete();
    pop_err_q.delete();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(2);
    n_cmp++;
    if ({m_arvalid, m_rready, inst_valid, inst_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 0000", {m_arvalid, m_rready, inst_valid, inst_err});
    end
    n_cmp++;
    if (m_araddr !== 32'h0) begin n_fail++; $display("FAIL reset_araddr got %h exp 00000000", m_araddr); end
    n_cmp++;
    if (inst_data !== 32'h0) begin n_fail++; $display("FAIL reset_inst_data got %h exp 00000000", inst_data); end
    n_cmp++;
    if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc got %h exp 00000000", inst_pc); end
  endtask

  task automatic test_basic();
    do_reset(1'b1, 1, 0);
    tick();
    n_cmp++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h0) begin
      n_fail++; $display("FAIL basic_first_ar got v=%b a=%h exp v=1 a=00000000", m_arvalid, m_araddr);
    end
    tick();
    n_cmp++;
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b exp 0", inst_valid); end
    tick();
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h0000_0013) begin
      n_fail++;
      $display("FAIL basic_first_inst got v=%b pc=%h d=%h exp v=1 pc=00000000 d=00000013", inst_valid, inst_pc, inst_data);
    end
    n_cmp++;
    if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL basic_arvalid_gap got %b exp 0", m_arvalid); end
    for (int k = 0; k < 40 && pop_pc_q.size() < 3; k++) tick();
    n_cmp++;
    if (at(ar_q, 0) !== 32'h0 || at(ar_q, 1) !== 32'h4 || at(ar_q, 2) !== 32'h8) begin
      n_fail++;
      $display("FAIL basic_ar_seq got %h %h %h exp 00000000 00000004 00000008", at(ar_q, 0), at(ar_q, 1), at(ar_q, 2));
    end
    n_cmp++;
    if (at(pop_pc_q, 1) !== 32'h4 || at(pop_data_q, 1) !== 32'hDEAD_0004 ||
        at(pop_pc_q, 2) !== 32'h8 || at(pop_data_q, 2) !== 32'hDEAD_0008) begin
      n_fail++;
      $display("FAIL basic_pops got %h/%h %h/%h exp 00000004/dead0004 00000008/dead0008",
               at(pop_pc_q, 1), at(pop_data_q, 1), at(pop_pc_q, 2), at(pop_data_q, 2));
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0, 1, 0);
    tick(12);
    n_cmp++;
    if (ar_q.size() != 2 || at(ar_q, 0) !== 32'h0 || at(ar_q, 1) !== 32'h4) begin
      n_fail++;
      $display("FAIL bp_reads got n=%0d %h %h exp n=2 00000000 00000004", ar_q.size(), at(ar_q, 0), at(ar_q, 1));
    end
    n_cmp++;
    if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL bp_arvalid got %b exp 0", m_arvalid); end
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h0000_0013) begin
      n_fail++;
      $display("FAIL bp_head got v=%b pc=%h d=%h exp v=1 pc=00000000 d=00000013", inst_valid, inst_pc, inst_data);
    end
    inst_ready = 1'b1;
    for (int k = 0; k < 40 && pop_pc_q.size() < 3; k++) tick();
    n_cmp++;
    if (at(pop_pc_q, 0) !== 32'h0 || at(pop_pc_q, 1) !== 32'h4 || at(pop_pc_q, 2) !== 32'h8 ||
        at(pop_data_q, 1) !== 32'hDEAD_0004) begin
      n_fail++;
      $display("FAIL bp_pop_order got %h %h %h d1=%h exp 00000000 00000004 00000008 d1=dead0004",
               at(pop_pc_q, 0), at(pop_pc_q, 1), at(pop_pc_q, 2), at(pop_data_q, 1));
    end
    n_cmp++;
    if (at(ar_q, 2) !== 32'h8) begin n_fail++; $display("FAIL bp_resume got %h exp 00000008", at(ar_q, 2)); end
  endtask

  task automatic test_ar_stall();
    do_reset(1'b1, 1, 0);
    for (int k = 0; k < 30 && ar_q.size() < 2; k++) tick();
    ar_wait = 3;
    for (int k = 0; k < 30 && !(m_arvalid === 1'b1 && m_araddr === 32'h8); k++) tick();
    n_cmp++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h8) begin
      n_fail++; $display("FAIL stall_wait got v=%b a=%h exp v=1 a=00000008", m_arvalid, m_araddr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (m_arvalid !== 1'b1 || m_araddr !== 32'h8) begin
        n_fail++; $display("FAIL stall_hold%0d got v=%b a=%h exp v=1 a=00000008", k, m_arvalid, m_araddr);
      end
    end
    for (int k = 0; k < 30 && pop_pc_q.size() < 3; k++) tick();
    n_cmp++;
    if (at(ar_q, 2) !== 32'h8 || at(ar_q, 3) === 32'h8) begin
      n_fail++; $display("FAIL stall_single_hs got %h %h exp 00000008 then not 00000008", at(ar_q, 2), at(ar_q, 3));
    end
    n_cmp++;
    if (at(pop_pc_q, 2) !== 32'h8 || at(pop_data_q, 2) !== 32'hDEAD_0008) begin
      n_fail++; $display("FAIL stall_pop got %h/%h exp 00000008/dead0008", at(pop_pc_q, 2), at(pop_data_q, 2));
    end
  endtask

  task automatic test_redirect_data();
    do_reset(1'b1, 1, 3);
    for (int k = 0; k < 200 && ar_q.size() < 8; k++) tick();
    inst_ready = 1'b0;
    for (int k = 0; k < 40 && ar_q.size() < 9; k++) tick();
    n_cmp++;
    if (at(ar_q, 8) !== 32'h20 || inst_valid !== 1'b1 || inst_pc !== 32'h1C || pop_pc_q.size() != 7) begin
      n_fail++;
      $display("FAIL redir_setup got ar=%h v=%b pc=%h pops=%0d exp ar=00000020 v=1 pc=0000001c pops=7",
               at(ar_q, 8), inst_valid, inst_pc, pop_pc_q.size());
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got %b exp 0", inst_valid); end
    inst_ready = 1'b1;
    for (int k = 0; k < 60 && pop_pc_q.size() < 8; k++) tick();
    n_cmp++;
    if (at(ar_q, 9) !== 32'h100) begin n_fail++; $display("FAIL redir_next_ar got %h exp 00000100", at(ar_q, 9)); end
    n_cmp++;
    if (at(pop_pc_q, 7) !== 32'h100 || at(pop_data_q, 7) !== 32'hDEAD_0100) begin
      n_fail++; $display("FAIL redir_next_inst got %h/%h exp 00000100/dead0100", at(pop_pc_q, 7), at(pop_data_q, 7));
    end
  endtask

  task automatic test_redirect_addr();
    do_reset(1'b1, 3, 0);
    tick();
    n_cmp++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h0) begin
      n_fail++; $display("FAIL radr_issue got v=%b a=%h exp v=1 a=00000000", m_arvalid, m_araddr);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0202;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h0) begin
      n_fail++; $display("FAIL radr_stable got v=%b a=%h exp v=1 a=00000000", m_arvalid, m_araddr);
    end
    for (int k = 0; k < 40 && pop_pc_q.size() < 1; k++) tick();
    n_cmp++;
    if (at(ar_q, 0) !== 32'h0 || at(ar_q, 1) !== 32'h200) begin
      n_fail++; $display("FAIL radr_ar_seq got %h %h exp 00000000 00000200", at(ar_q, 0), at(ar_q, 1));
    end
    n_cmp++;
    if (at(pop_pc_q, 0) !== 32'h200 || at(pop_data_q, 0) !== 32'hDEAD_0200) begin
      n_fail++; $display("FAIL radr_first_inst got %h/%h exp 00000200/dead0200", at(pop_pc_q, 0), at(pop_data_q, 0));
    end
  endtask

  task automatic test_bus_error();
    do_reset(1'b1, 1, 0);
    err_en         = 1;
    err_addr       = 32'h40;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (m_arvalid !== 1'b0) begin n_fail++; $display("FAIL err_idle_redirect got %b exp 0", m_arvalid); end
    for (int k = 0; k < 30 && pop_pc_q.size() < 1; k++) tick();
    n_cmp++;
    if (at(pop_pc_q, 0) !== 32'h40 || at(pop_err_q, 0) !== 32'h1) begin
      n_fail++; $display("FAIL err_entry got pc=%h err=%h exp pc=00000040 err=1", at(pop_pc_q, 0), at(pop_err_q, 0));
    end
    tick(10);
    n_cmp++;
    if (ar_q.size() != 1 || m_arvalid !== 1'b0) begin
      n_fail++; $display("FAIL err_halt got reads=%0d v=%b exp reads=1 v=0", ar_q.size(), m_arvalid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 30 && pop_pc_q.size() < 2; k++) tick();
    n_cmp++;
    if (at(ar_q, 1) !== 32'h80 || at(pop_pc_q, 1) !== 32'h80 || at(pop_err_q, 1) !== 32'h0) begin
      n_fail++;
      $display("FAIL err_resume got ar=%h pc=%h err=%h exp ar=00000080 pc=00000080 err=0",
               at(ar_q, 1), at(pop_pc_q, 1), at(pop_err_q, 1));
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b1, 1, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 30 && pop_pc_q.size() < 2; k++) tick();
    n_cmp++;
    if (at(ar_q, 0) !== 32'hFFFF_FFFC || at(ar_q, 1) !== 32'h0) begin
      n_fail++; $display("FAIL wrap_ar got %h %h exp fffffffc 00000000", at(ar_q, 0), at(ar_q, 1));
    end
    n_cmp++;
    if (at(pop_data_q, 0) !== 32'h2152_FFFC || at(pop_pc_q, 1) !== 32'h0 || at(pop_data_q, 1) !== 32'h0000_0013) begin
      n_fail++;
      $display("FAIL wrap_pops got d0=%h pc1=%h d1=%h exp d0=2152fffc pc1=00000000 d1=00000013",
               at(pop_data_q, 0), at(pop_pc_q, 1), at(pop_data_q, 1));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ar_stall();
    test_redirect_data();
    test_redirect_addr();
    test_bus_error();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
